// File: rtl/execute_redirect.sv
// ============================================================================
// Module      : execute_redirect
// Description : RV32I execute-stage branch/jump resolution, fetch redirect,
//               wrong-path squash and EX/MEM link-write register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_redirect #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             JalrE,
    input  logic [2:0]       Funct3E,
    input  logic [XLEN-1:0]  RD1E,
    input  logic [XLEN-1:0]  RD2E,
    input  logic [XLEN-1:0]  ImmExtE,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  PCPlus4E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    output logic             PCSrcE,
    output logic [XLEN-1:0]  PCTarget,
    output logic             SquashE,
    output logic             RegWriteM,
    output logic [4:0]       RdM,
    output logic [XLEN-1:0]  LinkM,
    output logic             MisalignM,
    output logic [CNT_W-1:0] RedirectCnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        KILL2 = 2'd1,
        KILL1 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_cond;
    logic              w_raw_taken;
    logic              w_squash;
    logic              w_pcsrc;
    logic [XLEN-1:0]   w_jalr_sum;
    logic [XLEN-1:0]   w_target;

    always_comb begin
        w_cond = 1'b0;
        case (Funct3E)
            3'b000:  w_cond = (RD1E == RD2E);
            3'b001:  w_cond = (RD1E != RD2E);
            3'b100:  w_cond = ($signed(RD1E) <  $signed(RD2E));
            3'b101:  w_cond = ($signed(RD1E) >= $signed(RD2E));
            3'b110:  w_cond = (RD1E <  RD2E);
            3'b111:  w_cond = (RD1E >= RD2E);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_jalr_sum  = RD1E + ImmExtE;
    assign w_target    = JalrE ? {w_jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);
    assign w_raw_taken = JumpE | JalrE | (BranchE & w_cond);
    assign w_squash    = (r_state != RUN);
    assign w_pcsrc     = w_raw_taken & ~w_squash;

    // Two wrong-path slots follow every redirect; taken-looking ones are ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_raw_taken) w_state_nxt = KILL2;
            KILL2:   w_state_nxt = KILL1;
            KILL1:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            RdM         <= 5'd0;
            LinkM       <= '0;
            MisalignM   <= 1'b0;
            RedirectCnt <= '0;
        end else begin
            RegWriteM   <= RegWriteE & ~w_squash;
            RdM         <= RdE;
            LinkM       <= PCPlus4E;
            MisalignM   <= w_pcsrc & w_target[1];
            if (w_pcsrc) begin
                RedirectCnt <= RedirectCnt + CNT_W'(1);
            end
        end
    end

    assign PCSrcE   = w_pcsrc;
    assign PCTarget = w_target;
    assign SquashE  = w_squash;

endmodule

`default_nettype wire

// File: tb/tb_execute_redirect.sv
// ============================================================================
// Module      : tb_execute_redirect
// Description : Directed vector bench for execute_redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_redirect;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             BranchE, JumpE, JalrE;
    logic [2:0]       Funct3E;
    logic [XLEN-1:0]  RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]       RdE;
    logic             RegWriteE;
    logic             PCSrcE;
    logic [XLEN-1:0]  PCTarget;
    logic             SquashE;
    logic             RegWriteM;
    logic [4:0]       RdM;
    logic [XLEN-1:0]  LinkM;
    logic             MisalignM;
    logic [CNT_W-1:0] RedirectCnt;

    execute_redirect #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .Funct3E(Funct3E),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RdE(RdE), .RegWriteE(RegWriteE),
        .PCSrcE(PCSrcE), .PCTarget(PCTarget), .SquashE(SquashE),
        .RegWriteM(RegWriteM), .RdM(RdM), .LinkM(LinkM),
        .MisalignM(MisalignM), .RedirectCnt(RedirectCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        b, j, jr;
        logic [2:0]  f3;
        logic [31:0] rd1, rd2, imm, pce, pcp4;
        logic [4:0]  rde;
        logic        rwe;
        logic        exp_pcsrc;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t             vecs[15];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] cnt_model = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One EX cycle: drive at negedge, check combinational outputs, then the EX/MEM register.
    task automatic step(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                        input logic [31:0] pce, input logic [31:0] pcp4, input logic [4:0] rde,
                        input logic rwe, input logic exp_pcsrc, input logic [31:0] exp_tgt,
                        input logic exp_sq);
        @(negedge clk);
        BranchE = b; JumpE = j; JalrE = jr; Funct3E = f3;
        RD1E = rd1; RD2E = rd2; ImmExtE = imm; PCE = pce; PCPlus4E = pcp4;
        RdE = rde; RegWriteE = rwe;
        #1;
        chk("PCSrcE",   {31'd0, PCSrcE},  {31'd0, exp_pcsrc});
        chk("PCTarget", PCTarget,         exp_tgt);
        chk("SquashE",  {31'd0, SquashE}, {31'd0, exp_sq});
        @(posedge clk);
        #1;
        if (exp_pcsrc) cnt_model = cnt_model + 1'b1;
        chk("RegWriteM",   {31'd0, RegWriteM}, {31'd0, rwe & ~exp_sq});
        chk("RdM",         {27'd0, RdM},       {27'd0, rde});
        chk("LinkM",       LinkM,              pcp4);
        chk("MisalignM",   {31'd0, MisalignM}, {31'd0, exp_pcsrc & exp_tgt[1]});
        chk("RedirectCnt", {28'd0, RedirectCnt}, {28'd0, cnt_model});
    endtask

    task automatic bubble(input logic exp_sq);
        step(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h500, 5'd7, 1'b1, 1'b0, 32'h0, exp_sq);
    endtask

    task automatic jal_redirect();
        step(0, 1, 0, 3'd0, 0, 0, 32'h40, 32'h80, 32'h84, 5'd1, 1'b1, 1'b1, 32'hC0, 1'b0);
        bubble(1'b1);
        bubble(1'b1);
    endtask

    initial begin
        //          b  j  jr f3    rd1           rd2           imm           pce           pcp4          rde rwe pcsrc tgt
        vecs[0]  = '{1, 0, 0, 3'd0, 32'h5,        32'h5,        32'h20,       32'h100,      32'h104,      5'd3, 1, 1, 32'h120};
        vecs[1]  = '{1, 0, 0, 3'd1, 32'h5,        32'h5,        32'h20,       32'h100,      32'h104,      5'd3, 1, 0, 32'h120};
        vecs[2]  = '{1, 0, 0, 3'd4, 32'hFFFFFFFF, 32'h1,        32'h8,        32'h200,      32'h204,      5'd4, 0, 1, 32'h208};
        vecs[3]  = '{1, 0, 0, 3'd6, 32'hFFFFFFFF, 32'h1,        32'h8,        32'h200,      32'h204,      5'd4, 0, 0, 32'h208};
        vecs[4]  = '{1, 0, 0, 3'd5, 32'h1,        32'hFFFFFFFF, 32'h10,       32'h0,        32'h4,        5'd5, 1, 1, 32'h10};
        vecs[5]  = '{1, 0, 0, 3'd7, 32'h1,        32'hFFFFFFFF, 32'h10,       32'h0,        32'h4,        5'd5, 1, 0, 32'h10};
        vecs[6]  = '{0, 0, 1, 3'd0, 32'h203,      32'h0,        32'h4,        32'h0,        32'h44,       5'd1, 1, 1, 32'h206};
        vecs[7]  = '{1, 0, 0, 3'd2, 32'h9,        32'h9,        32'h4,        32'h80,       32'h84,       5'd6, 1, 0, 32'h84};
        vecs[8]  = '{1, 0, 0, 3'd0, 32'h0,        32'h0,        32'h20,       32'hFFFFFFF0, 32'hFFFFFFF4, 5'd2, 0, 1, 32'h10};
        vecs[9]  = '{0, 1, 0, 3'd0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h1000,     32'h1004,     5'd1, 1, 1, 32'hFFC};
        vecs[10] = '{0, 1, 1, 3'd0, 32'h301,      32'h0,        32'h0,        32'h40,       32'h44,       5'd8, 1, 1, 32'h300};
        vecs[11] = '{0, 0, 0, 3'd0, 32'h7,        32'h7,        32'h4,        32'h80,       32'h84,       5'd9, 1, 0, 32'h84};
        vecs[12] = '{1, 0, 0, 3'd1, 32'h3,        32'h4,        32'h2,        32'h100,      32'h104,      5'd0, 0, 1, 32'h102};
        vecs[13] = '{1, 0, 0, 3'd7, 32'h5,        32'h5,        32'h8,        32'h0,        32'h4,        5'd10, 1, 1, 32'h8};
        vecs[14] = '{1, 0, 0, 3'd4, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h4,        32'h0,        32'h4,        5'd11, 1, 1, 32'h4};

        rst = 1'b0;
        BranchE = 0; JumpE = 0; JalrE = 0; Funct3E = 0;
        RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; RdE = 0; RegWriteE = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset RegWriteM",   {31'd0, RegWriteM},  32'd0);
        chk("reset RdM",         {27'd0, RdM},        32'd0);
        chk("reset LinkM",       LinkM,               32'd0);
        chk("reset MisalignM",   {31'd0, MisalignM},  32'd0);
        chk("reset RedirectCnt", {28'd0, RedirectCnt}, 32'd0);
        chk("reset SquashE",     {31'd0, SquashE},    32'd0);
        chk("reset PCSrcE",      {31'd0, PCSrcE},     32'd0);
        @(negedge clk);
        rst = 1'b1;

        // All-zero bubble from fetch reset must not redirect.
        step(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].b, vecs[i].j, vecs[i].jr, vecs[i].f3, vecs[i].rd1, vecs[i].rd2,
                 vecs[i].imm, vecs[i].pce, vecs[i].pcp4, vecs[i].rde, vecs[i].rwe,
                 vecs[i].exp_pcsrc, vecs[i].exp_tgt, 1'b0);
            bubble(vecs[i].exp_pcsrc);
            bubble(vecs[i].exp_pcsrc);
        end

        // JAL followed by two more JALs: only the first redirects.
        step(0, 1, 0, 3'd0, 0, 0, 32'h100, 32'h400, 32'h404, 5'd1, 1'b1, 1'b1, 32'h500, 1'b0);
        step(0, 1, 0, 3'd0, 0, 0, 32'h100, 32'h404, 32'h408, 5'd1, 1'b1, 1'b0, 32'h504, 1'b1);
        step(0, 1, 0, 3'd0, 0, 0, 32'h100, 32'h408, 32'h40C, 5'd1, 1'b1, 1'b0, 32'h508, 1'b1);
        step(0, 0, 0, 3'd0, 0, 0, 32'h0,   32'h500, 32'h504, 5'd12, 1'b1, 1'b0, 32'h500, 1'b0);

        // Reset asserted mid-squash aborts it without a clock edge.
        step(1, 0, 0, 3'd0, 32'h5, 32'h5, 32'h20, 32'h100, 32'h104, 5'd3, 1'b1, 1'b1, 32'h120, 1'b0);
        #2;
        chk("KILL2 entered SquashE", {31'd0, SquashE}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async SquashE",     {31'd0, SquashE},    32'd0);
        chk("async PCSrcE",      {31'd0, PCSrcE},     32'd1);
        chk("async RegWriteM",   {31'd0, RegWriteM},  32'd0);
        chk("async RdM",         {27'd0, RdM},        32'd0);
        chk("async LinkM",       LinkM,               32'd0);
        chk("async MisalignM",   {31'd0, MisalignM},  32'd0);
        chk("async RedirectCnt", {28'd0, RedirectCnt}, 32'd0);
        cnt_model = '0;
        @(negedge clk);
        BranchE = 0; JumpE = 0; JalrE = 0; RegWriteE = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 3'd0, 32'h1, 32'h2, 32'h0, 32'h600, 32'h604, 5'd13, 1'b1, 1'b0, 32'h600, 1'b0);

        // Counter wrap.
        for (int k = 0; k < 20 && cnt_model != {CNT_W{1'b1}}; k++) begin
            jal_redirect();
        end
        chk("RedirectCnt all-ones", {28'd0, RedirectCnt}, 32'hF);
        jal_redirect();
        chk("RedirectCnt wrap", {28'd0, RedirectCnt}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
